// File: rtl/wordline_pkg.sv
// Shared definitions for the wordline sequencer.
//   wl_state_e     : sequencer FSM state encoding
//   cnt_width()    : width of the WL/PRE duration down-counter
//   addr_w_legal() : legal row-address widths (even, 2..10)
//   cycles_legal() : legal WL/PRE durations (1..255)
package wordline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETUP     = 2'd1,
    ST_ACTIVE    = 2'd2,
    ST_PRECHARGE = 2'd3
  } wl_state_e;

  // Counter must hold the larger of the two durations; it never wraps.
  function automatic int cnt_width(input int wl_cycles, input int pre_cycles);
    int m;
    m = (wl_cycles > pre_cycles) ? wl_cycles : pre_cycles;
    return $clog2(m + 1);
  endfunction

  function automatic bit addr_w_legal(input int w);
    return (w >= 2) && (w <= 10) && ((w % 2) == 0);
  endfunction

  function automatic bit cycles_legal(input int c);
    return (c >= 1) && (c <= 255);
  endfunction

endpackage

// File: rtl/wl_predecode.sv
// Two-level row decoder.
//   clk, rst_n : clock, async active-low reset
//   load       : capture addr/all into the group registers
//   addr       : row address (ADDR_W bits)
//   all        : broadcast; every group goes all-ones
//   wl_dec     : decoded rows (2**ADDR_W bits), AND of one bit per group
// The registered one-hot groups are the captured request: they hold the
// address from accept until the next accept.
module wl_predecode
  import wordline_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 all,
  output logic [2**ADDR_W-1:0] wl_dec
);

  localparam int NG   = ADDR_W / 2;
  localparam int ROWS = 2 ** ADDR_W;

  logic [NG-1:0][3:0] grp_q, grp_d;
  logic               row_hit;
  logic [1:0]         sel;

  always_comb begin
    grp_d = grp_q;
    if (load) begin
      for (int g = 0; g < NG; g++) begin
        grp_d[g] = all ? 4'hF : (4'b0001 << addr[2*g +: 2]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grp_q <= '0;
    else        grp_q <= grp_d;
  end

  // Final AND stage: row r is selected when every group has the bit
  // matching its own 2-bit slice of r.
  always_comb begin
    wl_dec  = '0;
    row_hit = 1'b0;
    sel     = 2'd0;
    for (int r = 0; r < ROWS; r++) begin
      row_hit = 1'b1;
      for (int g = 0; g < NG; g++) begin
        sel     = r[2*g +: 2];
        row_hit = row_hit & grp_q[g][sel];
      end
      wl_dec[r] = row_hit;
    end
  end

endmodule

// File: rtl/wordline_sequencer.sv
// Wordline access sequencer: IDLE -> SETUP -> ACTIVE -> PRECHARGE.
//   clk, rst_n        : clock, async active-low reset
//   req_valid/ready   : request handshake, accept when both high
//   req_addr, req_all : row address / broadcast, captured on accept
//   wl                : registered wordlines (2**ADDR_W)
//   pre_n             : registered bitline precharge, active-low
//   busy, done        : registered status; done = final PRECHARGE cycle
//
// state        | meaning
// ST_IDLE      | waiting, bitlines precharged, ready
// ST_SETUP     | one cycle, predecode holds new address, wl all-zero
// ST_ACTIVE    | wordline(s) high for WL_CYCLES
// ST_PRECHARGE | wl low, pre_n low for PRE_CYCLES; last cycle ready+done
module wordline_sequencer
  import wordline_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int WL_CYCLES  = 2,
  parameter int PRE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_all,
  output logic [2**ADDR_W-1:0] wl,
  output logic                 pre_n,
  output logic                 busy,
  output logic                 done
);

  localparam int ROWS  = 2 ** ADDR_W;
  localparam int CNT_W = cnt_width(WL_CYCLES, PRE_CYCLES);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
    $error("wordline_sequencer: ADDR_W must be even and in 2..10");
  end
  if (!cycles_legal(WL_CYCLES)) begin : g_bad_wl_cycles
    $error("wordline_sequencer: WL_CYCLES must be in 1..255");
  end
  if (!cycles_legal(PRE_CYCLES)) begin : g_bad_pre_cycles
    $error("wordline_sequencer: PRE_CYCLES must be in 1..255");
  end

  wl_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0]   wl_q, wl_d;
  logic              pre_n_q, pre_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic [ROWS-1:0]   wl_dec;

  assign req_ready = (state_q == ST_IDLE) ||
                     ((state_q == ST_PRECHARGE) && (cnt_q == CNT_ONE));
  assign accept    = req_valid && req_ready;

  wl_predecode #(.ADDR_W(ADDR_W)) u_predecode (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .addr   (req_addr),
    .all    (req_all),
    .wl_dec (wl_dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACTIVE;
        cnt_d   = WL_LOAD;
      end
      ST_ACTIVE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_PRECHARGE;
          cnt_d   = PRE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_PRECHARGE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = accept ? ST_SETUP : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they land in flops and
    // change exactly on the state-transition edge.
    wl_d    = (state_d == ST_ACTIVE) ? wl_dec : '0;
    pre_n_d = (state_d == ST_ACTIVE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_PRECHARGE) && (cnt_d == CNT_ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wl_q    <= '0;
      pre_n_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wl_q    <= wl_d;
      pre_n_q <= pre_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wl    = wl_q;
  assign pre_n = pre_n_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_wordline_sequencer.sv
// Directed bench for wordline_sequencer: default instance (16 rows,
// WL=2, PRE=1) and a swept instance (64 rows, WL=4, PRE=3).
module tb_wordline_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v1, all1, ready1, pre1, busy1, done1;
  logic [3:0]  addr1;
  logic [15:0] wl1;

  logic        v2, all2, ready2, pre2, busy2, done2;
  logic [5:0]  addr2;
  logic [63:0] wl2;

  wordline_sequencer dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
    .req_addr(addr1), .req_all(all1), .wl(wl1), .pre_n(pre1),
    .busy(busy1), .done(done1)
  );

  wordline_sequencer #(.ADDR_W(6), .WL_CYCLES(4), .PRE_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(ready2),
    .req_addr(addr2), .req_all(all2), .wl(wl2), .pre_n(pre2),
    .busy(busy2), .done(done2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full status of the default instance.
  task automatic exp1(input string tag, input logic [15:0] w, input logic p,
                      input logic b, input logic d, input logic r);
    chk({tag, ".wl"},    64'(wl1),    64'(w));
    chk({tag, ".pre_n"}, 64'(pre1),   64'(p));
    chk({tag, ".busy"},  64'(busy1),  64'(b));
    chk({tag, ".done"},  64'(done1),  64'(d));
    chk({tag, ".ready"}, 64'(ready1), 64'(r));
  endtask

  task automatic exp2(input string tag, input logic [63:0] w, input logic p,
                      input logic b, input logic d, input logic r);
    chk({tag, ".wl"},    wl2,         w);
    chk({tag, ".pre_n"}, 64'(pre2),   64'(p));
    chk({tag, ".busy"},  64'(busy2),  64'(b));
    chk({tag, ".done"},  64'(done2),  64'(d));
    chk({tag, ".ready"}, 64'(ready2), 64'(r));
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; addr1 = '0; all1 = 1'b0;
    v2 = 1'b0; addr2 = '0; all2 = 1'b0;
    step();
    step();
    exp1("rst", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp2("rst2", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    exp1("idle", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single access, addr=5
    v1 = 1'b1; addr1 = 4'd5;
    step();
    v1 = 1'b0; addr1 = 4'd0;
    exp1("s.setup", 16'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp1("s.act1",  16'h0020, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("s.act2",  16'h0020, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("s.pre",   16'h0,    1'b0, 1'b1, 1'b1, 1'b1);
    step(); exp1("s.idle",  16'h0,    1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: addr=3, then addr=12 held valid
    v1 = 1'b1; addr1 = 4'd3;
    step();
    addr1 = 4'd12;
    exp1("b.setup1", 16'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.act1a",  16'h0008, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.act1b",  16'h0008, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.pre1",   16'h0,    1'b0, 1'b1, 1'b1, 1'b1);
    step();
    v1 = 1'b0; addr1 = 4'd0;
    exp1("b.setup2", 16'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.act2a",  16'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.act2b",  16'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("b.pre2",   16'h0,    1'b0, 1'b1, 1'b1, 1'b1);
    step(); exp1("b.idle",   16'h0,    1'b0, 1'b0, 1'b0, 1'b1);

    // Broadcast, addr=9
    v1 = 1'b1; all1 = 1'b1; addr1 = 4'd9;
    step();
    v1 = 1'b0; all1 = 1'b0; addr1 = 4'd0;
    exp1("a.setup", 16'h0,    1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp1("a.act1",  16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("a.act2",  16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp1("a.pre",   16'h0,    1'b0, 1'b1, 1'b1, 1'b1);
    step(); exp1("a.idle",  16'h0,    1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the first ACTIVE cycle, addr=7
    v1 = 1'b1; addr1 = 4'd7;
    step();
    v1 = 1'b0; addr1 = 4'd0;
    step();
    exp1("r.act", 16'h0080, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("r.async.wl",    64'(wl1),   64'h0);
    chk("r.async.pre_n", 64'(pre1),  64'h0);
    chk("r.async.busy",  64'(busy1), 64'h0);
    step();
    rst_n = 1'b1;
    step(); exp1("r.rel1", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step(); exp1("r.rel3", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Swept instance: addr=63, stray request during ACTIVE
    v2 = 1'b1; addr2 = 6'd63;
    step();
    v2 = 1'b0; addr2 = 6'd0;
    exp2("p.setup", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp2("p.act1", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    v2 = 1'b1; addr2 = 6'd1;
    step(); exp2("p.act2", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    v2 = 1'b0; addr2 = 6'd0;
    step(); exp2("p.act3", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp2("p.act4", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); exp2("p.pre1", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp2("p.pre2", 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); exp2("p.pre3", 64'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); exp2("p.idle", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); exp2("p.idle2", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp1("p.dut1_quiet", 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
